keypad_scanner: RTL

- Scans a 4x4 matrix keypad and delivers debounced single-key press events to the CPU side.
- Input-side counterpart of the multiplexed seg display: it drives one column enable at a time and reads the row lines back.
- Outputs are a latched key code with a valid/ack handshake, plus a one-cycle interrupt pulse intended for one bit of the CPU hardware_interrupt vector.
- Runs on a divided clock in the top level.

---
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with press/release debounce, latched key code, valid/ack handshake and irq pulse.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       clr,
    output logic [3:0] key_col_en,
    input  logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_irq,
    output logic       overrun
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0] NS = 4'(DEBOUNCE_SCANS);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    logic [3:0] row_meta, row_sync;
    logic [CW-1:0] dwell;
    logic [1:0] col;
    logic [11:0] snap;
    logic [15:0] keys;
    logic [4:0] nset;
    logic [3:0] code;
    logic tick, empty, single, accept;
    state_t state, state_n;
    logic [3:0] cand, cand_n, match, match_n, rel, rel_n;

    assign key_col_en = ~(4'b0001 << col);
    assign tick = dwell == LAST && col == 2'd3;
    assign empty = nset == 5'd0;
    assign single = nset == 5'd1;

    // columns 0..2 shift in from the top, so snap[c*4 +: 4] holds column c at scan end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            row_meta <= '1;
            row_sync <= '1;
            dwell    <= '0;
            col      <= '0;
            snap     <= '0;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
            dwell    <= dwell == LAST ? '0 : dwell + 1'b1;
            if (dwell == LAST) begin
                col <= col + 2'd1;
                if (col != 2'd3) snap <= {~row_sync, snap[11:4]};
            end
        end
    end

    always_comb begin
        keys = '0;
        for (int r = 0; r < 4; r++) begin
            keys[r*4]   = snap[r];
            keys[r*4+1] = snap[4+r];
            keys[r*4+2] = snap[8+r];
            keys[r*4+3] = ~row_sync[r];
        end
    end

    always_comb begin
        nset = '0;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            nset = nset + 5'(keys[i]);
            if (keys[i]) code = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cand  <= '0;
            match <= '0;
            rel   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            match <= match_n;
            rel   <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        match_n = match;
        rel_n   = rel;
        if (tick) begin
            case (state)
                IDLE: if (single) begin
                    cand_n  = code;
                    match_n = 4'd1;
                    state_n = NS == 4'd1 ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: if (!single) state_n = IDLE;
                else if (code != cand) begin
                    cand_n  = code;
                    match_n = 4'd1;
                end else begin
                    match_n = match + 4'd1;
                    state_n = match + 4'd1 == NS ? PRESSED : DEBOUNCE;
                end
                PRESSED: if (empty) begin
                    rel_n   = 4'd1;
                    state_n = NS == 4'd1 ? IDLE : RELEASE;
                end
                RELEASE: if (!empty) state_n = PRESSED;
                else begin
                    rel_n   = rel + 4'd1;
                    state_n = rel + 4'd1 == NS ? IDLE : RELEASE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        accept = tick && single &&
                 ((state == IDLE && NS == 4'd1) ||
                  (state == DEBOUNCE && code == cand && match + 4'd1 == NS));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_irq   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            key_irq <= accept;
            if (accept && (!key_valid || key_ack)) begin
                key_code  <= code;
                key_valid <= 1'b1;
                overrun   <= 1'b0;
            end else if (accept) begin
                overrun <= 1'b1;
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end
endmodule
